digit_scan_ctrl: RTL and testbench

- Time-multiplexing scan controller for the 4-digit common-anode 7-segment display.
- Generates the 2-bit digit index consumed by the ID-digit lookup and segment decoder.
- Generates the active-low one-hot digit-enable drive `ct`.
- Inserts a dark blanking interval between digits so segment data can settle, which prevents ghosting.

---
 rtl/digit_scan_ctrl.sv | 77 +++++++
 tb/tb_digit_scan_ctrl.sv | 105 ++++++++++
 2 files changed

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: 7-segment digit scanner with dark blanking between digits
module digit_scan_ctrl #(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int NUM_DIGITS   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    output logic [1:0] digit,
    output logic [3:0] ct,
    output logic       blank,
    output logic       frame_tick
);
    localparam int MAXC = DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW = $clog2(MAXC > 2 ? MAXC : 2);
    localparam logic [CW-1:0] DW_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BL_LAST = CW'(BLANK_CYCLES == 0 ? 0 : BLANK_CYCLES - 1);
    localparam logic [1:0] D_LAST = 2'(NUM_DIGITS - 1);
    localparam bit NO_BLANK = (BLANK_CYCLES == 0);
    typedef enum logic {S_BLANK, S_ON} state_t;
    state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [1:0] digit_d, digit_inc;
    logic [3:0] ct_d;
    logic blank_d, ft_d;
    assign digit_inc = (digit == D_LAST) ? 2'd0 : digit + 2'd1;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_BLANK;
            cnt        <= '0;
            digit      <= 2'd0;
            ct         <= 4'b1111;
            blank      <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            digit      <= digit_d;
            ct         <= ct_d;
            blank      <= blank_d;
            frame_tick <= ft_d;
        end
    end
    // en low holds the scan position but darkens the display on the next edge
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        digit_d = digit;
        ct_d    = 4'b1111;
        blank_d = 1'b1;
        ft_d    = 1'b0;
        if (en) begin
            if (state == S_BLANK) begin
                if (NO_BLANK || cnt == BL_LAST) begin
                    cnt_d   = '0;
                    state_d = S_ON;
                    ct_d    = ~(4'b0001 << digit);
                    blank_d = 1'b0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end else if (cnt == DW_LAST) begin
                cnt_d   = '0;
                digit_d = digit_inc;
                ft_d    = (digit_inc == 2'd0);
                state_d = NO_BLANK ? S_ON : S_BLANK;
                ct_d    = NO_BLANK ? ~(4'b0001 << digit_inc) : 4'b1111;
                blank_d = !NO_BLANK;
            end else begin
                cnt_d   = cnt + 1'b1;
                ct_d    = ~(4'b0001 << digit);
                blank_d = 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: directed table plus scan-schedule model across three configurations
module tb_digit_scan_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic en_a = 1'b1;
    logic [3:0] a_ct, b_ct, c_ct;
    logic [1:0] a_dg, b_dg, c_dg;
    logic a_bl, b_bl, c_bl, a_ft, b_ft, c_ft;
    int checks = 0;
    int failures = 0;
    typedef struct {
        logic       en;
        int         n;
        logic [3:0] ct;
        logic [1:0] d;
        logic       b;
        logic       ft;
    } vec_t;
    vec_t tbl[22];
    always #5 clk = ~clk;
    digit_scan_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(2), .NUM_DIGITS(4)) u_a (
        .clk(clk), .reset_n(reset_n), .en(en_a), .digit(a_dg), .ct(a_ct), .blank(a_bl), .frame_tick(a_ft)
    );
    digit_scan_ctrl #(.DWELL_CYCLES(3), .BLANK_CYCLES(0), .NUM_DIGITS(4)) u_b (
        .clk(clk), .reset_n(reset_n), .en(1'b1), .digit(b_dg), .ct(b_ct), .blank(b_bl), .frame_tick(b_ft)
    );
    digit_scan_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(2), .NUM_DIGITS(3)) u_c (
        .clk(clk), .reset_n(reset_n), .en(1'b1), .digit(c_dg), .ct(c_ct), .blank(c_bl), .frame_tick(c_ft)
    );
    task automatic chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s k=%0d got={ct,dg,bl,ft}=%h want=%h", nm, k, act, exp);
        end
    endtask
    // expected {ct,digit,blank,frame_tick} k cycles after reset release
    function automatic logic [7:0] model(input int k, input int dw, input int bl, input int n);
        int j, slot, p;
        logic [1:0] d;
        logic dark;
        if (bl == 0) begin
            if (k == 0) return {4'hF, 2'd0, 1'b1, 1'b0};
            j = k - 1;
            slot = j / dw;
            p = j % dw;
            dark = 1'b0;
        end else begin
            slot = k / (dw + bl);
            p = k % (dw + bl);
            dark = (p < bl);
        end
        d = 2'(slot % n);
        return {dark ? 4'hF : ~(4'b0001 << d), d, dark, (p == 0 && slot > 0 && d == 2'd0)};
    endfunction
    task automatic chk_bc(input int k);
        chk("b_noblank", k, {b_ct, b_dg, b_bl, b_ft}, model(k, 3, 0, 4));
        chk("c_3digit", k, {c_ct, c_dg, c_bl, c_ft}, model(k, 4, 2, 3));
    endtask
    initial begin
        int k;
        tbl = '{
            '{1, 2, 4'hF, 0, 1, 0}, '{1, 4, 4'hE, 0, 0, 0}, '{1, 2, 4'hF, 1, 1, 0}, '{1, 4, 4'hD, 1, 0, 0},
            '{1, 2, 4'hF, 2, 1, 0}, '{1, 4, 4'hB, 2, 0, 0}, '{1, 2, 4'hF, 3, 1, 0}, '{1, 4, 4'h7, 3, 0, 0},
            '{1, 1, 4'hF, 0, 1, 1}, '{1, 1, 4'hF, 0, 1, 0}, '{1, 4, 4'hE, 0, 0, 0}, '{1, 2, 4'hF, 1, 1, 0},
            '{1, 4, 4'hD, 1, 0, 0}, '{1, 2, 4'hF, 2, 1, 0}, '{1, 1, 4'hB, 2, 0, 0}, '{0, 1, 4'hB, 2, 0, 0},
            '{0, 4, 4'hF, 2, 1, 0}, '{1, 1, 4'hF, 2, 1, 0}, '{1, 2, 4'hB, 2, 0, 0}, '{1, 2, 4'hF, 3, 1, 0},
            '{1, 4, 4'h7, 3, 0, 0}, '{1, 1, 4'hF, 0, 1, 1}
        };
        repeat (3) begin
            @(negedge clk);
            chk("a_in_reset", 0, {a_ct, a_dg, a_bl, a_ft}, 8'hF2);
            chk("b_in_reset", 0, {b_ct, b_dg, b_bl, b_ft}, 8'hF2);
        end
        reset_n = 1'b1;
        k = 0;
        foreach (tbl[r]) begin
            for (int i = 0; i < tbl[r].n; i++) begin
                chk("a_table", k, {a_ct, a_dg, a_bl, a_ft}, {tbl[r].ct, tbl[r].d, tbl[r].b, tbl[r].ft});
                chk_bc(k);
                en_a = tbl[r].en;
                @(negedge clk);
                k++;
            end
        end
        for (int i = 0; i < 60 && a_ct != 4'b0111; i++) @(negedge clk);
        chk("a_reach_digit3", 0, {4'h0, a_ct}, 8'h07);
        #2 reset_n = 1'b0;
        #1;
        chk("a_async_rst", 0, {a_ct, a_dg, a_bl, a_ft}, 8'hF2);
        chk("c_async_rst", 0, {c_ct, c_dg, c_bl, c_ft}, 8'hF2);
        repeat (2) begin
            @(negedge clk);
            chk("a_rst_hold", 0, {a_ct, a_dg, a_bl, a_ft}, 8'hF2);
        end
        reset_n = 1'b1;
        for (k = 0; k < 30; k++) begin
            chk("a_rerun", k, {a_ct, a_dg, a_bl, a_ft}, model(k, 4, 2, 4));
            chk_bc(k);
            @(negedge clk);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
